store_log_fifo: RTL and testbench
=================================

Name: store_log_fifo

Overview:
- Records every data-memory store the single-cycle core retires into a small FIFO.
- The difftest bench drains one entry per handshake and compares it against the reference model's store, byte-masked.
- Sits beside Top's data_memory write port: the core is upstream, the bench store checker is downstream.
- Tags each entry with the retired-instruction index so stores can be aligned to difftest steps.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, 2 to 64.
- ADDR_W, 16, byte-address width of data memory.
- SEQ_W, 32, width of the retire sequence counter and entry tag.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- retire  input  1  one instruction retired this cycle.
- st_wb_en  input  4  byte write enables of the store retiring this cycle; 0 means no store.
- st_addr  input  ADDR_W  store byte address.
- st_data  input  32  store write data, unshifted lane layout as driven to the SRAM.
- out_valid  output  1  head entry is available.
- out_ready  input  1  bench accepts the head entry.
- out_wb_en  output  4  head entry byte enables.
- out_addr  output  ADDR_W  head entry word-aligned address; bits [1:0] are always 0.
- out_data  output  32  head entry data; lanes with wb_en=0 read as 0.
- out_seq  output  SEQ_W  retire index of the instruction that made the store.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a store was dropped because the FIFO was full.
- misaligned  output  1  sticky: a store had nonzero st_addr[1:0].

Behaviour:
- Reset (asynchronous, rst=1):
  - Pointers, count, seq counter and both sticky flags clear.
  - Outputs: out_valid=0, out_wb_en=0, out_addr=0, out_data=0, out_seq=0, count=0, overflow=0, misaligned=0.
  - Asserting reset mid-operation discards all entries immediately, with no drain.
- Sequence counter:
  - seq increments by 1 on each cycle with retire=1 and wraps modulo 2^SEQ_W.
  - A store is tagged with the seq value before this cycle's increment, so the first retired instruction is 0.
- Push condition: retire=1 AND st_wb_en!=0. A store with retire=0 is ignored.
- Stored fields:
  - Address is stored as {st_addr[ADDR_W-1:2],2'b00}.
  - Data is stored pre-masked per byte lane.
  - If st_addr[1:0]!=0, misaligned sets and the entry is still pushed.
- Pop condition: out_valid AND out_ready.
- Head output: registered FIFO head with no bypass. An entry pushed in cycle N is first visible at out_valid in cycle N+1.
- When empty:
  - out_valid=0.
  - out_wb_en, out_addr, out_data and out_seq hold 0. The bench may ignore them.
- Full and push, no pop in the same cycle:
  - The entry is dropped and overflow sets. Existing contents are unchanged.
- Full and push with pop in the same cycle:
  - Both are accepted; count stays at DEPTH and overflow is unchanged.
- Empty and push with out_ready=1: the push is accepted. There is no pop, since out_valid=0 this cycle.
- Pointer wrap: modulo DEPTH, using an extra-bit or count-based full/empty scheme. count must never exceed DEPTH.
- Sticky flags clear only on reset.
- No combinational path from any input to out_valid or out_* data.

Decomposition:
- store_log_pkg holds:
  - typedef struct packed store_entry_t {wb_en[3:0], addr[ADDR_W-1:0], data[31:0], seq[SEQ_W-1:0]}.
  - Function mask_lanes(wb_en, data).
  - Localparam defaults DEPTH_DEF=8, ADDR_W_DEF=16, SEQ_W_DEF=32.
- One sub-module, sync_fifo, is natural:
  - Parameterised by entry type width and DEPTH.
  - Provides push/pop/full/empty/count and the registered head.
- store_log_fifo wraps sync_fifo and adds the seq counter, masking, alignment and sticky flags.

Test Plan:
- Reset then idle: out_valid=0, count=0, overflow=0, misaligned=0.
- Single store, out_ready=0:
  - Stimulus: 3 retires without store, then retire with st_wb_en=4'b0011, st_addr=16'h1006, st_data=32'hDEADBEEF.
  - Next cycle: out_valid=1, out_addr=16'h1004, out_data=32'h0000BEEF, out_seq=3, misaligned=1.
- Back-to-back stores:
  - Stimulus: DEPTH+1 consecutive stores (wb_en=4'hF, data=i) with out_ready=0.
  - Response: count=8, overflow=1. Draining yields data 0..7 in order with seq ascending.
- Full with simultaneous push and pop: count stays 8, overflow unchanged, and the popped head is the oldest entry.
- Store with retire=0, or retire with wb_en=0: no push, count unchanged, seq increments only for the retire=1 case.
- Async reset asserted mid-drain with 5 entries queued: out_valid drops to 0 immediately without a clock edge, and count=0 after release.

Source files
------------

// File: rtl/store_log_fifo_pkg.sv
// store_log_pkg: shared entry type, lane-mask helper and default sizes for the store log.
package store_log_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int SEQ_W_DEF = 32;
  typedef struct packed {
    logic [3:0] wb_en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [31:0] data;
    logic [SEQ_W_DEF-1:0] seq;
  } store_entry_t;
  function automatic logic [31:0] mask_lanes(input logic [3:0] wb_en, input logic [31:0] data);
    return data & {{8{wb_en[3]}}, {8{wb_en[2]}}, {8{wb_en[1]}}, {8{wb_en[0]}}};
  endfunction
endpackage

// File: rtl/store_log_fifo_if.sv
// store_log_fifo_if: head-entry handshake between the store log and its consumer.
interface store_log_fifo_if #(parameter int ADDR_W = 16, parameter int SEQ_W = 32);
  logic out_valid;
  logic out_ready;
  logic [3:0] out_wb_en;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0] out_data;
  logic [SEQ_W-1:0] out_seq;
  modport master(output out_valid, out_wb_en, out_addr, out_data, out_seq, input out_ready);
  modport slave(input out_valid, out_wb_en, out_addr, out_data, out_seq, output out_ready);
endinterface

// File: rtl/store_log_fifo_sync_fifo.sv
// sync_fifo: count-based FIFO with a registered head that reads as zero when empty.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    do_pop = pop & ~empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    do_push = push & (~full | do_pop);
    wr_d = do_push ? wr_q + PW'(1) : wr_q;
    rd_d = do_pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    count = cnt_q;
    head = empty ? '0 : mem_q[rd_q];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/store_log_fifo.sv
// store_log_fifo: logs retired stores (masked, word-aligned, seq-tagged) into a FIFO for difftest.
module store_log_fifo
  import store_log_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic retire,
  input  logic [3:0] st_wb_en,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0] st_data,
  store_log_fifo_if.master out,
  output logic [$clog2(DEPTH):0] count,
  output logic overflow,
  output logic misaligned
);
  localparam int E_W = 4 + ADDR_W + 32 + SEQ_W;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic ovf_q, ovf_d, mis_q, mis_d;
  logic push, pop, full, empty;
  logic [E_W-1:0] din, head;
  always_comb begin
    push = retire & (|st_wb_en);
    pop = out.out_ready & ~empty;
    din = {st_wb_en, st_addr[ADDR_W-1:2], 2'b00, mask_lanes(st_wb_en, st_data), seq_q};
    seq_d = retire ? seq_q + SEQ_W'(1) : seq_q;
    ovf_d = ovf_q | (push & full & ~pop);
    mis_d = mis_q | (push & (|st_addr[1:0]));
    overflow = ovf_q;
    misaligned = mis_q;
    out.out_valid = ~empty;
    {out.out_wb_en, out.out_addr, out.out_data, out.out_seq} = head;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seq_q <= '0;
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  sync_fifo #(.W(E_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .full(full), .empty(empty), .count(count), .head(head)
  );
endmodule

// File: tb/tb_store_log_fifo.sv
// tb_store_log_fifo: directed stimulus with a queue scoreboard drained by an independent monitor.
module tb_store_log_fifo;
  logic clk = 0, rst = 1, retire = 0;
  logic [3:0] st_wb_en = 0;
  logic [15:0] st_addr = 0;
  logic [31:0] st_data = 0;
  logic [3:0] count;
  logic overflow, misaligned;
  int tests = 0, fails = 0;
  logic [31:0] seq_m = 0;
  logic [83:0] sb [$];
  store_log_fifo_if #(.ADDR_W(16), .SEQ_W(32)) bus ();
  store_log_fifo dut (
    .clk(clk), .rst(rst), .retire(retire), .st_wb_en(st_wb_en), .st_addr(st_addr),
    .st_data(st_data), .out(bus.master), .count(count), .overflow(overflow), .misaligned(misaligned)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_pop", 96'(bus.out_seq), 96'hFFFF_FFFF_FFFF);
      else chk("sb_entry", 96'({bus.out_wb_en, bus.out_addr, bus.out_data, bus.out_seq}), 96'(sb.pop_front()));
    end
  task automatic step(input logic r, input logic [3:0] wb, input logic [15:0] a,
                      input logic [31:0] d, input logic rdy, input logic [31:0] exp_data, input logic exp);
    retire = r; st_wb_en = wb; st_addr = a; st_data = d; bus.out_ready = rdy;
    if (exp) sb.push_back({wb, a & 16'hFFFC, exp_data, seq_m});
    if (r) seq_m++;
    @(posedge clk); #1;
  endtask
  initial begin
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", 96'(bus.out_valid), 0);
    chk("rst_count", 96'(count), 0);
    chk("rst_ovf", 96'(overflow), 0);
    chk("rst_mis", 96'(misaligned), 0);
    chk("rst_data", 96'(bus.out_data), 0);
    chk("rst_seq", 96'(bus.out_seq), 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 4'b0011, 16'h1006, 32'hDEADBEEF, 0, 32'h0000BEEF, 1);
    chk("single_valid", 96'(bus.out_valid), 1);
    chk("single_addr", 96'(bus.out_addr), 96'h1004);
    chk("single_data", 96'(bus.out_data), 96'h0000BEEF);
    chk("single_seq", 96'(bus.out_seq), 3);
    chk("single_mis", 96'(misaligned), 1);
    chk("single_count", 96'(count), 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("drain1_count", 96'(count), 0);
    chk("drain1_valid", 96'(bus.out_valid), 0);
    step(0, 4'hF, 16'h2000, 32'h1234, 0, 0, 0);
    chk("noretire_count", 96'(count), 0);
    step(1, 4'h0, 16'h2000, 32'h1234, 0, 0, 0);
    chk("nowb_count", 96'(count), 0);
    for (int i = 0; i < 8; i++) step(1, 4'hF, 16'h0100 + 16'(4 * i), 32'(i), 0, 32'(i), 1);
    chk("fill_count", 96'(count), 8);
    chk("fill_ovf", 96'(overflow), 0);
    chk("fill_head_seq", 96'(bus.out_seq), 5);
    step(1, 4'hF, 16'h0200, 32'hAAAA5555, 1, 32'hAAAA5555, 1);
    chk("pushpop_count", 96'(count), 8);
    chk("pushpop_ovf", 96'(overflow), 0);
    chk("pushpop_head_seq", 96'(bus.out_seq), 6);
    step(1, 4'hF, 16'h0300, 32'h9, 0, 0, 0);
    chk("ovf_count", 96'(count), 8);
    chk("ovf_flag", 96'(overflow), 1);
    chk("ovf_head_seq", 96'(bus.out_seq), 6);
    repeat (8) step(0, 0, 0, 0, 1, 0, 0);
    chk("drain_count", 96'(count), 0);
    chk("drain_sb", 96'(sb.size()), 0);
    for (int i = 0; i < 6; i++) step(1, 4'b1100, 16'h0400 + 16'(4 * i), 32'hCAFE0000 + 32'(i), 0, 32'hCAFE0000, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("pre_rst_count", 96'(count), 5);
    bus.out_ready = 0;
    #2 rst = 1;
    #1 chk("async_valid", 96'(bus.out_valid), 0);
    sb.delete();
    seq_m = 0;
    @(posedge clk); #1 rst = 0;
    chk("post_rst_count", 96'(count), 0);
    chk("post_rst_ovf", 96'(overflow), 0);
    chk("post_rst_mis", 96'(misaligned), 0);
    step(1, 4'b0100, 16'h0008, 32'h11223344, 0, 32'h00220000, 1);
    chk("post_rst_seq", 96'(bus.out_seq), 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("final_sb", 96'(sb.size()), 0);
    chk("final_count", 96'(count), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
